// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the serial boot loader.
package rom_loader_pkg;

  localparam int unsigned LEN_W          = 32;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned MEM_DEEPTH_DEF = 4096;

  // Loader protocol states
  typedef enum logic [2:0] {
    S_LEN   = 3'd0,
    S_DATA  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } ld_state_e;

  // UART receiver states
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // One ROM write transaction
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } rom_wr_t;

  // Clock cycles per UART bit
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Byte address of word number idx
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  idx);
    return base + ADDR_W'(idx << 2);
  endfunction

endpackage

// File: rtl/rom_loader_uart_rx.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling, byte/framing-error pulses.
module rom_loader_uart_rx
  import rom_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic              uart_rx_i,
  output logic              rx_valid_o,
  output logic [BYTE_W-1:0] rx_byte_o,
  output logic              frame_err_o
);

  localparam int unsigned CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned BIT_W = 3;

  logic              rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;

  // Two-flop synchroniser plus edge-detect history; line idles high
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Receiver state and datapath registers
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Bit timing: confirm start at half bit, then sample each bit centre
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_prev_q && !rx_s2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_W'(CPB / 2 - 1)) begin
          cnt_d   = '0;
          state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[BYTE_W-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(BYTE_W - 1)) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_s2_q) valid_d = 1'b1;
          else         ferr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_valid_o  = valid_q;
  assign rx_byte_o   = shift_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/rom_loader.sv
// Serial boot loader: UART image -> ROM write port, core held until load completes.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned       CLK_FREQ   = 100_000_000,
  parameter int unsigned       BAUD       = 115_200,
  parameter int unsigned       MEM_DEEPTH = MEM_DEEPTH_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned       TIMEOUT    = 1_000_000
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic              uart_rx_i,
  output logic              w_ena_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [WORD_W-1:0] w_data_o,
  output logic              cpu_hold_o,
  output logic              load_done_o,
  output logic              load_err_o
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  logic              rx_valid;
  logic [BYTE_W-1:0] rx_byte;
  logic              frame_err;

  ld_state_e         state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  rom_wr_t           wr_q, wr_d;
  logic              w_ena_q, w_ena_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [LEN_W-1:0]  len_shift;
  logic [WORD_W-1:0] word_shift;
  logic              idle_expired;

  rom_loader_uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk_100MHz  (clk_100MHz),
    .rst         (rst),
    .uart_rx_i   (uart_rx_i),
    .rx_valid_o  (rx_valid),
    .rx_byte_o   (rx_byte),
    .frame_err_o (frame_err)
  );

  // Little-endian assembly: each new byte enters at the top and slides down
  assign len_shift    = {rx_byte, len_q[LEN_W-1:BYTE_W]};
  assign word_shift   = {rx_byte, word_q[WORD_W-1:BYTE_W]};
  assign idle_expired = (idle_q == IDLE_W'(TIMEOUT - 1));

  // Loader state, datapath and registered outputs
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q    <= S_LEN;
      byte_cnt_q <= '0;
      len_q      <= '0;
      word_q     <= '0;
      word_cnt_q <= '0;
      idle_q     <= '0;
      wr_q       <= '0;
      w_ena_q    <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      word_q     <= word_d;
      word_cnt_q <= word_cnt_d;
      idle_q     <= idle_d;
      wr_q       <= wr_d;
      w_ena_q    <= w_ena_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Protocol FSM: length, data bytes, single-cycle write, terminal states
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    word_d     = word_q;
    word_cnt_d = word_cnt_q;
    idle_d     = idle_q;
    wr_d       = wr_q;
    unique case (state_q)
      S_LEN: begin
        if (frame_err) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          len_d      = len_shift;
          byte_cnt_d = byte_cnt_q + 2'd1;
          idle_d     = '0;
          if (byte_cnt_q == 2'd3) begin
            if (len_shift == '0)                       state_d = S_DONE;
            else if (len_shift > LEN_W'(MEM_DEEPTH))   state_d = S_ERR;
            else                                       state_d = S_DATA;
          end
        end else if (byte_cnt_q != 2'd0) begin
          if (idle_expired) state_d = S_ERR;
          else              idle_d  = idle_q + IDLE_W'(1);
        end
      end
      S_DATA: begin
        if (frame_err) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          word_d     = word_shift;
          byte_cnt_d = byte_cnt_q + 2'd1;
          idle_d     = '0;
          if (byte_cnt_q == 2'd3) begin
            state_d   = S_WRITE;
            wr_d.addr = word_addr(BASE_ADDR, word_cnt_q);
            wr_d.data = word_shift;
          end
        end else if (idle_expired) begin
          state_d = S_ERR;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + LEN_W'(1);
        if (frame_err) begin
          state_d = S_ERR;
        end else if (word_cnt_q + LEN_W'(1) == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
          // A byte landing here is kept so no data is lost
          if (rx_valid) begin
            word_d     = word_shift;
            byte_cnt_d = byte_cnt_q + 2'd1;
            idle_d     = '0;
          end
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // Outputs follow the state being entered so they line up with it
  always_comb begin
    w_ena_d = (state_d == S_WRITE);
    hold_d  = (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
  end

  assign w_ena_o     = w_ena_q;
  assign w_addr_o    = wr_q.addr;
  assign w_data_o    = wr_q.data;
  assign cpu_hold_o  = hold_q;
  assign load_done_o = done_q;
  assign load_err_o  = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: vector table plus corner-case sequences.
module tb_rom_loader;

  localparam int unsigned CPB     = 16;
  localparam int unsigned TO      = 400;
  localparam int unsigned DEPTH   = 4096;
  localparam logic [31:0] BASE    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        w_ena;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [31:0] n;
    int unsigned words;
    int unsigned extra;
    bit          wait_to;
    logic        done;
    logic        err;
  } vec_t;
  vec_t vecs[6];

  rom_loader #(
    .CLK_FREQ   (CPB),
    .BAUD       (1),
    .MEM_DEEPTH (DEPTH),
    .BASE_ADDR  (BASE),
    .TIMEOUT    (TO)
  ) dut (
    .clk_100MHz  (clk),
    .rst         (rst),
    .uart_rx_i   (rx),
    .w_ena_o     (w_ena),
    .w_addr_o    (w_addr),
    .w_data_o    (w_data),
    .cpu_hold_o  (cpu_hold),
    .load_done_o (load_done),
    .load_err_o  (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] tmp;
      tmp = w >> (8 * i);
      send_byte(tmp[7:0], 1'b1);
    end
  endtask

  task automatic send_data_word(input logic [31:0] w, input int unsigned idx);
    wr_t e;
    e.addr = BASE + 32'(idx * 4);
    e.data = w;
    exp_q.push_back(e);
    send_word(w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " w_ena"},     32'(w_ena),     32'd0);
    check({tag, " w_addr"},    w_addr,         32'd0);
    check({tag, " w_data"},    w_data,         32'd0);
    check({tag, " cpu_hold"},  32'(cpu_hold),  32'd1);
    check({tag, " load_done"}, 32'(load_done), 32'd0);
    check({tag, " load_err"},  32'(load_err),  32'd0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, " pending writes"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Write scoreboard and pulse-timing monitor
  initial begin : monitor
    logic prev_rv, prev_we, prev_done;
    wr_t  e;
    prev_rv = 1'b0; prev_we = 1'b0; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        prev_rv = 1'b0; prev_we = 1'b0; prev_done = 1'b0;
      end else begin
        if (w_ena) begin
          check("w_ena one clock after 4th byte", 32'(prev_rv), 32'd1);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected write: addr %h data %h, none expected", w_addr, w_data);
          end else begin
            e = exp_q.pop_front();
            check("w_addr", w_addr, e.addr);
            check("w_data", w_data, e.data);
          end
        end
        if (load_done && !prev_done)
          check("load_done latency", 32'(prev_rv | prev_we), 32'd1);
        prev_rv   = dut.rx_valid;
        prev_we   = w_ena;
        prev_done = load_done;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vecs[0] = '{n: 32'd2,    words: 2, extra: 0, wait_to: 1'b0, done: 1'b1, err: 1'b0};
    vecs[1] = '{n: 32'd0,    words: 0, extra: 0, wait_to: 1'b0, done: 1'b1, err: 1'b0};
    vecs[2] = '{n: 32'd4097, words: 0, extra: 0, wait_to: 1'b0, done: 1'b0, err: 1'b1};
    vecs[3] = '{n: 32'd3,    words: 1, extra: 1, wait_to: 1'b1, done: 1'b0, err: 1'b1};
    vecs[4] = '{n: 32'd4096, words: 0, extra: 0, wait_to: 1'b0, done: 1'b0, err: 1'b0};
    vecs[5] = '{n: 32'd3,    words: 3, extra: 0, wait_to: 1'b0, done: 1'b1, err: 1'b0};

    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Table-driven loads
    foreach (vecs[v]) begin
      do_reset();
      send_word(vecs[v].n);
      for (int w = 0; w < int'(vecs[v].words); w++) begin
        logic [31:0] d;
        d = (w == 0) ? 32'hDEADBEEF : (w == 1) ? 32'h00000013 : $urandom;
        send_data_word(d, w);
      end
      for (int b = 0; b < int'(vecs[v].extra); b++)
        send_byte(8'($urandom), 1'b1);
      if (vecs[v].wait_to) repeat (TO + 50) @(negedge clk);
      else                 repeat (20) @(negedge clk);
      check($sformatf("vec%0d load_done", v), 32'(load_done), 32'(vecs[v].done));
      check($sformatf("vec%0d load_err", v),  32'(load_err),  32'(vecs[v].err));
      check($sformatf("vec%0d cpu_hold", v),  32'(cpu_hold),  32'(!vecs[v].done));
      check($sformatf("vec%0d w_ena idle", v), 32'(w_ena), 32'd0);
      if (vecs[v].words > 0)
        check($sformatf("vec%0d w_addr held", v), w_addr, BASE + 32'(4 * (vecs[v].words - 1)));
      check_drained($sformatf("vec%0d", v));
    end

    // Short glitch on idle line must not produce a byte
    do_reset();
    rx = 1'b0;
    repeat (CPB / 2 - 2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    send_word(32'd1);
    send_data_word(32'hCAFEF00D, 0);
    repeat (20) @(negedge clk);
    check("glitch load_done", 32'(load_done), 32'd1);
    check("glitch load_err",  32'(load_err),  32'd0);
    check_drained("glitch");

    // Bad stop bit on 2nd data byte: error, no writes, later bytes ignored
    do_reset();
    send_word(32'd2);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    repeat (20) @(negedge clk);
    check("frame load_err",   32'(load_err),  32'd1);
    check("frame cpu_hold",   32'(cpu_hold),  32'd1);
    check("frame load_done",  32'(load_done), 32'd0);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_word(32'h55667788);
    repeat (20) @(negedge clk);
    check("frame err sticky", 32'(load_err),  32'd1);
    check_drained("frame");

    // Reset mid-load, then a fresh single-word load
    do_reset();
    send_word(32'd4);
    send_data_word(32'h01234567, 0);
    send_byte(8'hAB, 1'b1);
    check("midload addr before rst", w_addr, BASE);
    check("midload data before rst", w_data, 32'h01234567);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midload rst");
    rst = 1'b0;
    check_drained("midload");
    send_word(32'd1);
    send_data_word(32'hA5A55A5A, 0);
    repeat (20) @(negedge clk);
    check("reload load_done", 32'(load_done), 32'd1);
    check("reload cpu_hold",  32'(cpu_hold),  32'd0);
    check_drained("reload");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
